// File: rtl/object_state_arbiter_pkg.sv
// Shared types and constants for the object-table write arbiter.
// Field indices, the per-object state layout and the FSM encoding.
package obj_state_pkg;

    localparam int FIELD_W = 11;

    localparam int IMG_ID = 0;
    localparam int X      = 1;
    localparam int Y      = 2;
    localparam int W      = 3;
    localparam int H      = 4;

    typedef logic [0:4][0:FIELD_W-1] obj_state_t;

    typedef enum logic [1:0] {
        IDLE,
        PICK,
        ISSUE
    } arb_state_t;

endpackage

// File: rtl/object_state_arbiter_if.sv
// Valid/ready write channel into the object table.
// The arbiter drives it as master, the table answers as slave.
interface object_state_arbiter_if #(
    parameter int FIELD_W = 11
) ();

    logic                    wr_valid;
    logic                    wr_ready;
    logic [2:0]              wr_slot;
    logic [0:4][FIELD_W-1:0] wr_state;

    modport master (
        output wr_valid,
        output wr_slot,
        output wr_state,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_slot,
        input  wr_state,
        output wr_ready
    );

endinterface

// File: rtl/object_state_arbiter_rr_pick.sv
// Round-robin first-set search over the pending mask.
// Scans upward from ptr and wraps at NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] mask,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   sel,
    output logic               any
);

    // Lowest set bit below ptr is the fallback; lowest at/above ptr wins.
    always_comb begin
        sel = '0;
        any = 1'b0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (mask[j] && (j < int'(ptr))) begin
                any = 1'b1;
                sel = IDX_W'(j);
            end
        end
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (mask[j] && (j >= int'(ptr))) begin
                any = 1'b1;
                sel = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/object_state_arbiter.sv
// Serializes per-frame object states into the object table, round-robin.
// Optional OBJ_ARB_OVERRUN_CNT_EN adds a saturating 8-bit overrun_count.
module object_state_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int FIELD_W = 11
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 frame_start,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ-1:0][0:4][FIELD_W-1:0] req_state,
    output logic [NUM_REQ-1:0]                   req_ack,
    object_state_arbiter_if.master               wr,
    output logic                                 frame_done,
    output logic                                 overrun
`ifdef OBJ_ARB_OVERRUN_CNT_EN
    ,
    output logic [7:0]                           overrun_count
`endif
);

    import obj_state_pkg::*;

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef logic [0:4][FIELD_W-1:0] state_t;

    arb_state_t           state_q, state_d;
    logic [NUM_REQ-1:0]   pend_q, pend_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     slot_q, slot_d;
    logic                 valid_q, valid_d;
    state_t               data_q, data_d;
    logic                 done_q, done_d;
    logic                 ovr_q, ovr_d;

    logic [IDX_W-1:0]     sel;
    logic                 any;
    logic [IDX_W-1:0]     ptr_inc;
    logic                 xfer;

    assign ptr_inc = (ptr_q == IDX_W'(NUM_REQ - 1)) ? '0
                                                    : ptr_q + IDX_W'(1);
    assign xfer    = valid_q & wr.wr_ready;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .mask (pend_q),
        .ptr  (ptr_q),
        .sel  (sel),
        .any  (any)
    );

    // Next-state: snapshot on frame_start, pick one object, hold it until accepted.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        ptr_d   = ptr_q;
        slot_d  = slot_q;
        valid_d = valid_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ovr_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (frame_start) begin
                    pend_d = req_valid;
                    ptr_d  = ptr_inc;
                    if (req_valid == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = PICK;
                    end
                end
            end
            PICK: begin
                if (frame_start) begin
                    ovr_d   = 1'b1;
                    pend_d  = req_valid;
                    ptr_d   = ptr_inc;
                    state_d = (req_valid != '0) ? PICK : IDLE;
                end else if (any) begin
                    slot_d         = sel;
                    data_d[IMG_ID] = req_state[sel][IMG_ID];
                    data_d[X]      = req_state[sel][X];
                    data_d[Y]      = req_state[sel][Y];
                    data_d[W]      = req_state[sel][W];
                    data_d[H]      = req_state[sel][H];
                    pend_d[sel]    = 1'b0;
                    valid_d        = 1'b1;
                    state_d        = ISSUE;
                end else begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (frame_start) begin
                    ovr_d   = 1'b1;
                    valid_d = 1'b0;
                    pend_d  = req_valid;
                    ptr_d   = ptr_inc;
                    state_d = (req_valid != '0) ? PICK : IDLE;
                end else if (xfer) begin
                    valid_d = 1'b0;
                    if (pend_q != '0) begin
                        state_d = PICK;
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pend_q  <= '0;
            ptr_q   <= '0;
            slot_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ptr_q   <= ptr_d;
            slot_q  <= slot_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    // Ack the requester whose state the table accepts this cycle.
    always_comb begin
        req_ack = '0;
        if (xfer) begin
            req_ack[slot_q] = 1'b1;
        end
    end

    assign wr.wr_valid = valid_q;
    assign wr.wr_slot  = 3'(slot_q);
    assign wr.wr_state = data_q;
    assign frame_done  = done_q;
    assign overrun     = ovr_q;

`ifdef OBJ_ARB_OVERRUN_CNT_EN
    logic [7:0] ocnt_q;

    // Saturating count of overrun pulses, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ocnt_q <= '0;
        end else if (ovr_d && (ocnt_q != 8'hFF)) begin
            ocnt_q <= ocnt_q + 8'd1;
        end
    end

    assign overrun_count = ocnt_q;
`endif

endmodule

// File: tb/tb_object_state_arbiter.sv
// Scoreboard bench for object_state_arbiter.
// Expected writes are queued at frame_start and checked on each transfer.
module tb_object_state_arbiter;

    localparam int N  = 4;
    localparam int FW = 11;

    typedef logic [0:4][FW-1:0] st_t;
    typedef struct {
        logic [2:0] slot;
        st_t        st;
    } exp_t;

    logic                       clk;
    logic                       reset;
    logic                       frame_start;
    logic [N-1:0]               req_valid;
    logic [N-1:0][0:4][FW-1:0]  req_state;
    logic [N-1:0]               req_ack;
    logic                       frame_done;
    logic                       overrun;
`ifdef OBJ_ARB_OVERRUN_CNT_EN
    logic [7:0]                 overrun_count;
`endif

    object_state_arbiter_if #(.FIELD_W(FW)) wr ();

    object_state_arbiter #(
        .NUM_REQ (N),
        .FIELD_W (FW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .frame_start   (frame_start),
        .req_valid     (req_valid),
        .req_state     (req_state),
        .req_ack       (req_ack),
        .wr            (wr),
        .frame_done    (frame_done),
        .overrun       (overrun)
`ifdef OBJ_ARB_OVERRUN_CNT_EN
        ,
        .overrun_count (overrun_count)
`endif
    );

    int   vec = 0;
    int   err = 0;
    int   cyc = 0;
    int   t_fs = 0;
    int   xfer_cnt = 0;
    int   ovr_seen = 0;
    int   m_ptr = 0;
    int   x0;
    int   o0;
    exp_t sb_q[$];
    exp_t mon_e;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        vec++;
        if (got !== exp) begin
            err++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    // Transfer monitor: every accepted write must match the queue head.
    always @(negedge clk) begin
        if (!reset) begin
            if (wr.wr_valid && wr.wr_ready) begin
                xfer_cnt++;
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 64'(wr.wr_slot), 64'hFF);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("slot", 64'(wr.wr_slot), 64'(mon_e.slot));
                    chk("state", 64'(wr.wr_state), 64'(mon_e.st));
                    chk("ack", 64'(req_ack), 64'(4'b0001 << mon_e.slot));
                end
            end else begin
                chk("idle_ack", 64'(req_ack), 64'h0);
            end
            if (overrun) ovr_seen++;
        end
    end

    // Pulse frame_start for one cycle, then queue the expected write order.
    task automatic start_frame(input logic [N-1:0] m, input bit ovr);
        int s;
        req_valid   = m;
        frame_start = 1'b1;
        t_fs        = cyc;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        if (ovr) sb_q.delete();
        m_ptr = (m_ptr + 1) % N;
        for (int k = 0; k < N; k++) begin
            s = (m_ptr + k) % N;
            if (m[s]) sb_q.push_back('{slot: 3'(s), st: req_state[s]});
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 50) begin
            @(negedge clk);
            if (wr.wr_valid) seen = 1'b1;
            else n++;
        end
        chk("valid_seen", 64'(seen), 64'h1);
    endtask

    task automatic wait_done(input int lat);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
            else n++;
        end
        chk("done_seen", 64'(seen), 64'h1);
        if (seen && lat >= 0) chk("done_lat", 64'(cyc - t_fs), 64'(lat));
        chk("sb_drained", 64'(sb_q.size()), 64'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        frame_start = 1'b0;
        req_valid   = '0;
        wr.wr_ready = 1'b0;
        for (int s = 0; s < N; s++) begin
            req_state[s] = {11'(s + 1), 11'(100 * s + 7), 11'(200 + s),
                            11'(16 << s), 11'(11'h7FF - s)};
        end
        req_state[3] = {11'h7FF, 11'h000, 11'h555, 11'h2AA, 11'h7FF};

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", 64'(wr.wr_valid), 64'h0);
        chk("rst_slot", 64'(wr.wr_slot), 64'h0);
        chk("rst_state", 64'(wr.wr_state), 64'h0);
        chk("rst_ack", 64'(req_ack), 64'h0);
        chk("rst_done", 64'(frame_done), 64'h0);
        chk("rst_ovr", 64'(overrun), 64'h0);
        @(posedge clk);
        #1;

        // Full frame: slots 1,2,3,0, done at t+9.
        wr.wr_ready = 1'b1;
        x0 = xfer_cnt;
        start_frame(4'hF, 1'b0);
        wait_done(9);
        chk("full_xfers", 64'(xfer_cnt - x0), 64'd4);

        // Sparse mask with a 3-cycle stall on the first write.
        wr.wr_ready = 1'b0;
        x0 = xfer_cnt;
        start_frame(4'b1010, 1'b0);
        wait_valid();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) req_state[sb_q[0].slot] = '1;
            @(negedge clk);
            chk("stall_valid", 64'(wr.wr_valid), 64'h1);
            chk("stall_slot", 64'(wr.wr_slot), 64'(sb_q[0].slot));
            chk("stall_state", 64'(wr.wr_state), 64'(sb_q[0].st));
        end
        @(posedge clk);
        #1;
        wr.wr_ready = 1'b1;
        wait_done(-1);
        chk("sparse_xfers", 64'(xfer_cnt - x0), 64'd2);

        // Empty frame: done at t+1, no writes.
        x0 = xfer_cnt;
        start_frame(4'h0, 1'b0);
        wait_done(1);
        chk("empty_xfers", 64'(xfer_cnt - x0), 64'd0);

        // Overrun while stalled in ISSUE: write dropped, new mask serviced.
        wr.wr_ready = 1'b0;
        x0 = xfer_cnt;
        o0 = ovr_seen;
        start_frame(4'hF, 1'b0);
        wait_valid();
        @(posedge clk);
        #1;
`ifdef OBJ_ARB_OVERRUN_CNT_EN
        chk("ocnt_pre", 64'(overrun_count), 64'd0);
`endif
        start_frame(4'b0101, 1'b1);
        @(negedge clk);
        chk("drop_ovr", 64'(overrun), 64'h1);
        chk("drop_valid", 64'(wr.wr_valid), 64'h0);
`ifdef OBJ_ARB_OVERRUN_CNT_EN
        chk("ocnt_one", 64'(overrun_count), 64'd1);
`endif
        @(posedge clk);
        #1;
        wr.wr_ready = 1'b1;
        wait_done(-1);
        chk("drop_xfers", 64'(xfer_cnt - x0), 64'd2);
        chk("drop_ovr_cnt", 64'(ovr_seen - o0), 64'd1);

        // Overrun coinciding with a transfer: that write still completes.
        x0 = xfer_cnt;
        start_frame(4'hF, 1'b0);
        wait_valid();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        start_frame(4'b0011, 1'b1);
        @(negedge clk);
        chk("coinc_ovr", 64'(overrun), 64'h1);
        chk("coinc_old_xfers", 64'(xfer_cnt - x0), 64'd2);
        wait_done(5);
        chk("coinc_xfers", 64'(xfer_cnt - x0), 64'd4);

`ifdef OBJ_ARB_OVERRUN_CNT_EN
        // Back-to-back frame_starts push the counter into saturation.
        wr.wr_ready = 1'b0;
        for (int i = 0; i < 300; i++) start_frame(4'hF, 1'b1);
        @(negedge clk);
        chk("ocnt_sat", 64'(overrun_count), 64'd255);
        @(posedge clk);
        #1;
`endif

        // Reset during ISSUE, then the next frame starts at slot 1.
        wr.wr_ready = 1'b0;
        start_frame(4'hF, 1'b1);
        wait_valid();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_valid", 64'(wr.wr_valid), 64'h0);
        chk("mid_rst_slot", 64'(wr.wr_slot), 64'h0);
        chk("mid_rst_state", 64'(wr.wr_state), 64'h0);
        chk("mid_rst_ack", 64'(req_ack), 64'h0);
        chk("mid_rst_done", 64'(frame_done), 64'h0);
        chk("mid_rst_ovr", 64'(overrun), 64'h0);
`ifdef OBJ_ARB_OVERRUN_CNT_EN
        chk("mid_rst_ocnt", 64'(overrun_count), 64'd0);
`endif
        sb_q.delete();
        m_ptr = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        wr.wr_ready = 1'b1;
        start_frame(4'hF, 1'b0);
        wait_valid();
        chk("post_rst_slot", 64'(wr.wr_slot), 64'd1);
        wait_done(9);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
